alu_serial: RTL

Bit-serial 32-bit ALU sequencer that feeds the team's 1-bit ALU slice, `alu1`, one bit per clock.
- Latches operands and opcode on a start handshake.
- Walks bits LSB to MSB through a single `alu1` instance, holding the ripple carry in a flip-flop.
- Presents a registered result with flags and a one-cycle done pulse.
- Area-reduced drop-in alternative to the 32-slice ripple ALU, for control paths where latency is acceptable.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu1.sv | 30 +++
 rtl/alu_serial.sv | 124 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and counter sizing for the bit-serial ALU.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/alu1.sv
// One-bit ALU slice: op[2] inverts B, op[1:0] picks AND / OR / SUM / LESS.
module alu1 (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       less,
    input  logic [2:0] op,
    output logic       out,
    output logic       cout,
    output logic       set
);

    logic b_eff;
    logic sum;

    always_comb begin
        b_eff = b ^ op[2];
        sum   = a ^ b_eff ^ cin;
        cout  = (a & b_eff) | (a & cin) | (b_eff & cin);
        set   = sum;
        out   = 1'b0;
        case (op[1:0])
            2'b00:   out = a & b_eff;
            2'b01:   out = a | b_eff;
            2'b10:   out = sum;
            default: out = less;
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU sequencer driving one alu1 slice LSB-first; WIDTH+1 cycle latency.
// Optional signed-overflow output is enabled by defining ALU_SERIAL_OVF_EN.
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout
`ifdef ALU_SERIAL_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_q, b_q, shift_q, res_next;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             carry_ff, set_msb;
    logic             slice_out, slice_cout, slice_set;
    logic             accept, last, load_out;
`ifdef ALU_SERIAL_OVF_EN
    logic             c_msb_in;
`endif

    alu1 u_slice (
        .a    (a_q[cnt]),
        .b    (b_q[cnt]),
        .cin  (carry_ff),
        .less (1'b0),
        .op   (op_q),
        .out  (slice_out),
        .cout (slice_cout),
        .set  (slice_set)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == RUN);
        load_out = (state == DONE);
        accept   = start && ((state == IDLE) || (state == DONE));
        last     = (cnt == CW'(WIDTH - 1));
        // Set-less-than opcodes report only the sign of the MSB sum.
        res_next = (op_q[1:0] == OP_SLT[1:0]) ? {{(WIDTH-1){1'b0}}, set_msb} : shift_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            shift_q  <= '0;
            cnt      <= '0;
            carry_ff <= 1'b0;
            set_msb  <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            cout     <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
            c_msb_in <= 1'b0;
            overflow <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_q      <= a;
                b_q      <= b;
                op_q     <= op;
                carry_ff <= op[2];
                cnt      <= '0;
            end
            if (busy) begin
                shift_q[cnt] <= slice_out;
                carry_ff     <= slice_cout;
                if (last) begin
                    set_msb <= slice_set;
`ifdef ALU_SERIAL_OVF_EN
                    c_msb_in <= carry_ff;
`endif
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            // Outputs read the pre-edge carry even when a new start reloads it here.
            if (load_out) begin
                result <= res_next;
                zero   <= (res_next == '0);
                cout   <= carry_ff;
                done   <= 1'b1;
`ifdef ALU_SERIAL_OVF_EN
                overflow <= c_msb_in ^ carry_ff;
`endif
            end
        end
    end

endmodule
